// File: rtl/psec_spi_pkg.sv
// psec_spi_pkg: shared FSM state type, command layout and address helper for the SPI register bank
package psec_spi_pkg;
  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} spi_state_t;
  localparam int CMD_RW_BIT = 7;
  // Read/write registers start at address 1, so register index is address minus one
  function automatic int addr_to_idx(input logic [6:0] a);
    return int'(a) - 1;
  endfunction
endpackage

// File: rtl/psec_spi_regbank_if.sv
// psec_spi_regbank_if: SPI pad pins (csb frame select, pico data in, poci_spi data out); master drives csb/pico
interface psec_spi_regbank_if;
  logic csb;
  logic pico;
  logic poci_spi;
  modport master(output csb, pico, input poci_spi);
  modport slave(input csb, pico, output poci_spi);
endinterface

// File: rtl/psec_spi_shifter.sv
// psec_spi_shifter: rx/tx byte shifters and bit counter; ports clk, rst, active (csb low), pico, load/load_data (tx reload), byte_done, rx_byte, bit_cnt, poci
module psec_spi_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       active,
  input  logic       pico,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic       byte_done,
  output logic [7:0] rx_byte,
  output logic [2:0] bit_cnt,
  output logic       poci
);
  logic [6:0] rx;
  logic [7:0] tx;
  // rx_byte includes the bit arriving this edge so the top can act on the 8th-bit edge
  assign rx_byte   = {rx, pico};
  assign byte_done = active && bit_cnt == 3'd7;
  assign poci      = tx[7];
  always_ff @(posedge clk) begin
    if (rst) begin
      rx      <= '0;
      tx      <= '0;
      bit_cnt <= '0;
    end else if (!active) begin
      tx      <= '0;
      bit_cnt <= '0;
    end else begin
      rx      <= rx_byte[6:0];
      bit_cnt <= bit_cnt + 3'd1;
      tx      <= load ? load_data : {tx[6:0], 1'b0};
    end
  end
endmodule

// File: rtl/psec_spi_regbank.sv
// psec_spi_regbank: SPI slave register bank; ports spi_clk, rst, spi (csb/pico/poci_spi), status_in, cfg_regs, inst_pulse, wr_strobe
module psec_spi_regbank
  import psec_spi_pkg::*;
#(
  parameter int                    ADDR_W  = 7,
  parameter int                    NUM_RW  = 16,
  parameter logic [NUM_RW*8-1:0]   RW_RST  = '0,
  parameter int                    INST_W  = 8,
  parameter int                    STAT_W  = 8,
  parameter logic [7:0]            CHIP_ID = 8'hC6
) (
  input  logic                spi_clk,
  input  logic                rst,
  psec_spi_regbank_if.slave   spi,
  input  logic [STAT_W-1:0]   status_in,
  output logic [NUM_RW*8-1:0] cfg_regs,
  output logic [INST_W-1:0]   inst_pulse,
  output logic [NUM_RW-1:0]   wr_strobe
);
  localparam logic [ADDR_W-1:0] LAST_RW   = ADDR_W'(NUM_RW);
  localparam logic [ADDR_W-1:0] INST_ADDR = ADDR_W'(NUM_RW + 1);
  localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(NUM_RW + 2);
  localparam logic [ADDR_W-1:0] ERR_ADDR  = ADDR_W'(NUM_RW + 3);
  spi_state_t        state, state_n;
  logic [ADDR_W-1:0] addr, rd_addr;
  logic [7:0]        err_cnt, rdata, rx_byte;
  logic [2:0]        bit_cnt;
  logic              byte_done, load, poci, wr, frame_err;
  psec_spi_shifter u_shift (
    .clk(spi_clk), .rst, .active(!spi.csb), .pico(spi.pico), .load, .load_data(rdata),
    .byte_done, .rx_byte, .bit_cnt, .poci
  );
  assign spi.poci_spi = state == RDATA && poci;
  assign wr           = byte_done && state == WDATA;
  assign frame_err    = spi.csb && state != IDLE && bit_cnt != 3'd0;
  // tx reloads at the end of a read command and at the end of every read data byte
  assign load         = byte_done && ((state == CMD && !rx_byte[CMD_RW_BIT]) || state == RDATA);
  assign rd_addr      = state == CMD ? rx_byte[ADDR_W-1:0] : addr + 1'b1;
  assign state_n = spi.csb ? IDLE :
                   state == IDLE ? CMD :
                   (state == CMD && byte_done) ? (rx_byte[CMD_RW_BIT] ? WDATA : RDATA) : state;
  always_comb begin
    rdata = 8'h00;
    if (rd_addr == '0) rdata = CHIP_ID;
    else if (rd_addr <= LAST_RW) rdata = cfg_regs[addr_to_idx(rd_addr)*8 +: 8];
    else if (rd_addr == STAT_ADDR) rdata = 8'(status_in);
    else if (rd_addr == ERR_ADDR) rdata = err_cnt;
  end
  always_ff @(posedge spi_clk) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      cfg_regs   <= RW_RST;
      inst_pulse <= '0;
      wr_strobe  <= '0;
      err_cnt    <= '0;
    end else begin
      state      <= state_n;
      inst_pulse <= '0;
      wr_strobe  <= '0;
      if (byte_done && state == CMD) addr <= rx_byte[ADDR_W-1:0];
      else if (byte_done && state != IDLE) addr <= addr + 1'b1;
      if (wr && addr != '0 && addr <= LAST_RW) begin
        cfg_regs[addr_to_idx(addr)*8 +: 8] <= rx_byte;
        wr_strobe[addr_to_idx(addr)]       <= 1'b1;
      end
      if (wr && addr == INST_ADDR) inst_pulse <= rx_byte[INST_W-1:0];
      if (wr && addr == ERR_ADDR) err_cnt <= '0;
      else if (frame_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_psec_spi_regbank.sv
// tb_psec_spi_regbank: directed, table-driven checks of the SPI register bank
module tb_psec_spi_regbank;
  localparam logic [127:0] RST_IMG = 128'h1F1E1D1C1B1A19181716151413121110;
  typedef struct {
    string      name;
    logic [7:0] cmd;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;
  logic         clk = 0, rst = 1;
  logic [7:0]   status_in = 0;
  logic [127:0] cfg_regs;
  logic [7:0]   inst_pulse, inst_last;
  logic [15:0]  wr_strobe;
  int           n_checks = 0, n_fail = 0, inst_cycles = 0;
  int           strobe_cnt [16];
  vec_t         vecs [10];
  psec_spi_regbank_if sif ();
  psec_spi_regbank #(.RW_RST(RST_IMG)) dut (
    .spi_clk(clk), .rst, .spi(sif.slave), .status_in, .cfg_regs, .inst_pulse, .wr_strobe
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    for (int k = 0; k < 16; k++) strobe_cnt[k] += int'(wr_strobe[k]);
    if (inst_pulse != 0) begin
      inst_cycles++;
      inst_last = inst_pulse;
    end
  end
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic clear_mon();
    for (int k = 0; k < 16; k++) strobe_cnt[k] = 0;
    inst_cycles = 0;
    inst_last   = 0;
  endtask
  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      rx[i]    = sif.poci_spi;
      sif.pico = tx[i];
      sif.csb  = 0;
    end
  endtask
  task automatic end_frame();
    @(negedge clk);
    sif.csb  = 1;
    sif.pico = 0;
    @(negedge clk);
  endtask
  task automatic partial(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      sif.pico = 1;
      sif.csb  = 0;
    end
  endtask
  task automatic wr1(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] r;
    xfer({1'b1, a}, r);
    xfer(d, r);
    end_frame();
  endtask
  task automatic rd1(input logic [6:0] a, output logic [7:0] d);
    logic [7:0] r;
    xfer({1'b0, a}, r);
    xfer(8'h00, d);
    end_frame();
  endtask
  initial begin
    logic [7:0] r, r2;
    sif.csb  = 1;
    sif.pico = 0;
    repeat (3) @(negedge clk);
    check("rst_cfg", cfg_regs, RST_IMG);
    check("rst_inst", inst_pulse, 0);
    check("rst_strobe", wr_strobe, 0);
    check("rst_poci", sif.poci_spi, 0);
    rst = 0;
    clear_mon();
    // burst write A5,3C,0F starting at address 1
    xfer(8'h81, r);
    xfer(8'hA5, r);
    xfer(8'h3C, r);
    xfer(8'h0F, r);
    end_frame();
    check("burst_reg0", cfg_regs[7:0], 8'hA5);
    check("burst_reg1", cfg_regs[15:8], 8'h3C);
    check("burst_reg2", cfg_regs[23:16], 8'h0F);
    check("burst_upper", cfg_regs[127:24], RST_IMG[127:24]);
    for (int k = 0; k < 4; k++) check($sformatf("strobe%0d", k), strobe_cnt[k], k < 3 ? 1 : 0);
    status_in = 8'h01;
    vecs[0] = '{"rd_id",      8'h00, 8'h00, 8'hC6};
    vecs[1] = '{"rd_reg0",    8'h01, 8'h00, 8'hA5};
    vecs[2] = '{"rd_reg2",    8'h03, 8'h00, 8'h0F};
    vecs[3] = '{"rd_reg3",    8'h04, 8'h00, 8'h13};
    vecs[4] = '{"wr_reg15",   8'h90, 8'h77, 8'h00};
    vecs[5] = '{"rd_reg15",   8'h10, 8'h00, 8'h77};
    vecs[6] = '{"rd_stat",    8'h12, 8'h00, 8'h01};
    vecs[7] = '{"rd_err",     8'h13, 8'h00, 8'h00};
    vecs[8] = '{"rd_oor",     8'h7F, 8'h00, 8'h00};
    vecs[9] = '{"rd_inst",    8'h11, 8'h00, 8'h00};
    foreach (vecs[v]) begin
      if (vecs[v].cmd[7]) wr1(vecs[v].cmd[6:0], vecs[v].data);
      else begin
        rd1(vecs[v].cmd[6:0], r);
        check(vecs[v].name, r, vecs[v].exp);
      end
    end
    check("poci_idle", sif.poci_spi, 0);
    // instruction pulse
    clear_mon();
    wr1(7'h11, 8'h05);
    check("inst_cycles", inst_cycles, 1);
    check("inst_value", inst_last, 8'h05);
    rd1(7'h11, r);
    check("inst_readback", r, 8'h00);
    // abort after 4 data bits
    clear_mon();
    xfer(8'h81, r);
    partial(4);
    end_frame();
    check("abort_reg0", cfg_regs[7:0], 8'hA5);
    check("abort_strobe", strobe_cnt[0], 0);
    rd1(7'h13, r);
    check("abort_err", r, 8'h01);
    wr1(7'h13, 8'h5A);
    rd1(7'h13, r);
    check("err_clear", r, 8'h00);
    // burst read across the address wrap
    xfer(8'h7F, r);
    xfer(8'h00, r);
    xfer(8'h00, r2);
    end_frame();
    check("wrap_7f", r, 8'h00);
    check("wrap_00", r2, 8'hC6);
    // reset in the middle of the second data byte of a burst write
    xfer(8'h81, r);
    partial(3);
    end_frame();
    xfer(8'h81, r);
    xfer(8'h11, r);
    partial(4);
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    sif.csb = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("mid_rst_cfg", cfg_regs, RST_IMG);
    rd1(7'h13, r);
    check("mid_rst_err", r, 8'h00);
    rd1(7'h01, r);
    check("mid_rst_reg0", r, 8'h10);
    wr1(7'h02, 8'hC3);
    check("post_rst_wr", cfg_regs[15:8], 8'hC3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end
endmodule
